// File: rtl/wide_adder_arbiter_pkg.sv
// Shared types and widths for the wide accumulate-adder arbiter.
//   A_W / B_W / S_W : operand A, operand B and sum widths
//   arb_state_t     : arbiter FSM state (free round-robin vs. locked burst)
package adder_arb_pkg;
  localparam int A_W = 59;
  localparam int B_W = 26;
  localparam int S_W = 60;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/wide_adder_arbiter_if.sv
// Request/response bundle between two mantissa pipelines and the shared adder.
//   req_*_0 / req_*_1 : per-requester operands, tag, lock and valid/ready
//   rsp_*             : single registered response channel
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the sender holds its payload stable while valid && !ready and never
// drops valid before the transfer.
interface wide_adder_arbiter_if #(
  parameter int TAG_W = 4
);
  import adder_arb_pkg::*;

  logic             req_valid_0, req_valid_1;
  logic             req_ready_0, req_ready_1;
  logic [A_W-1:0]   req_a_0, req_a_1;
  logic [B_W-1:0]   req_b_0, req_b_1;
  logic [TAG_W-1:0] req_tag_0, req_tag_1;
  logic             req_lock_0, req_lock_1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [S_W-1:0]   rsp_sum;

  // Requesters plus response consumer.
  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_tag_0, req_tag_1, req_lock_0, req_lock_1, rsp_ready,
    input  req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_tag, rsp_sum
  );

  // Arbiter side.
  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_tag_0, req_tag_1, req_lock_0, req_lock_1, rsp_ready,
    output req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_tag, rsp_sum
  );
endinterface

// File: rtl/wide_adder_arbiter_adder.sv
// customAdder59_33: purely combinational 59-bit + 26-bit unsigned adder.
//   a   : 59-bit operand
//   b   : 26-bit operand, zero-extended (33 zero bits) to 59 bits
//   sum : 60-bit result, carry out in bit 59
module customAdder59_33 (
  input  logic [58:0] a,
  input  logic [25:0] b,
  output logic [59:0] sum
);
  assign sum = {1'b0, a} + {34'b0, b};
endmodule

// File: rtl/wide_adder_arbiter.sv
// wide_adder_arbiter: round-robin arbiter sharing one wide adder between two
// requesters, with optional burst lock and a single registered response.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : request/response bundle (slave side)
//   dbg_state      : current FSM state
//   dbg_last_grant : requester that won the most recent accepted beat
module wide_adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_adder_arbiter_if.slave  bus,
  output arb_state_t           dbg_state,
  output logic                 dbg_last_grant
);
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  arb_state_t       state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_grant, last_grant_nxt;
  logic [7:0]       burst_cnt, burst_cnt_nxt;
  logic [7:0]       cnt_inc;

  logic             out_free;
  logic             grant_0, grant_1;
  logic             accept;
  logic             sel;
  logic             sel_lock;
  logic             owner_valid;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [S_W-1:0]   sum;

  logic             rsp_valid_q, rsp_id_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [S_W-1:0]   rsp_sum_q;

  // A new beat may enter only if the response slot is empty or draining now.
  assign out_free = !rsp_valid_q || bus.rsp_ready;

  // Grant selection; in a tie the requester that did not win last goes.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (state == ARB_LOCKED) begin
      grant_0 = !owner && bus.req_valid_0;
      grant_1 = owner && bus.req_valid_1;
    end else if (bus.req_valid_0 && bus.req_valid_1) begin
      grant_0 = last_grant;
      grant_1 = !last_grant;
    end else begin
      grant_0 = bus.req_valid_0;
      grant_1 = bus.req_valid_1;
    end
  end

  assign sel         = grant_1;
  assign accept      = (grant_0 || grant_1) && out_free;
  assign sel_a       = sel ? bus.req_a_1   : bus.req_a_0;
  assign sel_b       = sel ? bus.req_b_1   : bus.req_b_0;
  assign sel_tag     = sel ? bus.req_tag_1 : bus.req_tag_0;
  assign sel_lock    = sel ? bus.req_lock_1 : bus.req_lock_0;
  assign owner_valid = owner ? bus.req_valid_1 : bus.req_valid_0;
  assign cnt_inc     = burst_cnt + 8'd1;

  customAdder59_33 u_adder (
    .a   (sel_a),
    .b   (sel_b),
    .sum (sum)
  );

  // Next-state logic. Under backpressure accept is 0 and out_free is 0, so
  // nothing below moves and lock/round-robin state is frozen.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      ARB_IDLE: begin
        if (accept) begin
          last_grant_nxt = sel;
          if (sel_lock && (MAX_B > 8'd1)) begin
            state_nxt     = ARB_LOCKED;
            owner_nxt     = sel;
            burst_cnt_nxt = 8'd1;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          burst_cnt_nxt = cnt_inc;
          if (!sel_lock || (cnt_inc >= MAX_B)) begin
            state_nxt     = ARB_IDLE;
            burst_cnt_nxt = 8'd0;
          end
        end else if (!owner_valid && out_free) begin
          state_nxt     = ARB_IDLE;
          burst_cnt_nxt = 8'd0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      burst_cnt   <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= sel;
        rsp_tag_q   <= sel_tag;
        rsp_sum_q   <= sum;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.req_ready_0 = grant_0 && out_free;
    bus.req_ready_1 = grant_1 && out_free;
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_id      = rsp_id_q;
    bus.rsp_tag     = rsp_tag_q;
    bus.rsp_sum     = rsp_sum_q;
    dbg_state       = state;
    dbg_last_grant  = last_grant;
  end
endmodule

// File: tb/tb_wide_adder_arbiter.sv
module tb_wide_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int TAG_W     = 4;
  localparam int MAX_BURST = 3;

  localparam logic [A_W-1:0] A_MAX = {A_W{1'b1}};

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  logic       dbg_last_grant;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [64:0] exp_q[$];

  wide_adder_arbiter_if #(.TAG_W(TAG_W)) bus ();

  wide_adder_arbiter #(.TAG_W(TAG_W), .MAX_BURST(MAX_BURST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_last_grant (dbg_last_grant)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           id;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [3:0]     tag;
    logic [S_W-1:0] exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string name, input logic [64:0] exp);
    n_cmp++;
    if (!bus.rsp_valid || {bus.rsp_id, bus.rsp_tag, bus.rsp_sum} !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b id/tag/sum=%0h expected %0h",
               name, bus.rsp_valid, {bus.rsp_id, bus.rsp_tag, bus.rsp_sum}, exp);
    end
  endtask

  task automatic check_ready(input string name, input logic r0, input logic r1);
    check(name, {62'b0, bus.req_ready_1, bus.req_ready_0}, {62'b0, r1, r0});
  endtask

  // Drivers
  task automatic clear_reqs();
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.req_lock_0  = 1'b0; bus.req_lock_1  = 1'b0;
    bus.req_a_0 = '0; bus.req_a_1 = '0;
    bus.req_b_0 = '0; bus.req_b_1 = '0;
    bus.req_tag_0 = '0; bus.req_tag_1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single req0 beat so that last_grant becomes 0 and req1 wins the next tie.
  task automatic prime_req0();
    bus.req_valid_0 = 1'b1;
    bus.req_a_0 = 59'd10; bus.req_b_0 = 26'd5; bus.req_tag_0 = 4'd3;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 59'h1, 26'h3FF_FFFF, 4'd5, 60'h000_0000_0400_0000};
    vecs[1] = '{1'b0, A_MAX, 26'h1, 4'd6, 60'h800_0000_0000_0000};
    vecs[2] = '{1'b1, A_MAX, 26'h3FF_FFFF, 4'd7, 60'h800_0000_03FF_FFFE};
    vecs[3] = '{1'b1, 59'h0, 26'h0, 4'hF, 60'h0};
    vecs[4] = '{1'b0, 59'h123_4567_89AB_CDEF, 26'h2B_CDEF, 4'd9, 60'h123_4567_89D7_9BDE};
    vecs[5] = '{1'b1, 59'h400_0000_0000_0000, 26'h200_0000, 4'd2, 60'h400_0000_0200_0000};

    // Reset values
    rst_n = 1'b0;
    clear_reqs();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check("reset_rsp_fields", {bus.rsp_id, bus.rsp_tag, bus.rsp_sum}, 64'd0);
    check("reset_state", {63'b0, dbg_state == ARB_IDLE}, 64'd1);
    check("reset_last_grant", {63'b0, dbg_last_grant}, 64'd1);
    rst_n = 1'b1;

    // Table-driven single requests
    for (int i = 0; i < 6; i++) begin
      clear_reqs();
      if (vecs[i].id) begin
        bus.req_valid_1 = 1'b1; bus.req_a_1 = vecs[i].a;
        bus.req_b_1 = vecs[i].b; bus.req_tag_1 = vecs[i].tag;
      end else begin
        bus.req_valid_0 = 1'b1; bus.req_a_0 = vecs[i].a;
        bus.req_b_0 = vecs[i].b; bus.req_tag_0 = vecs[i].tag;
      end
      #1;
      check_ready($sformatf("vec%0d_ready", i), !vecs[i].id, vecs[i].id);
      @(negedge clk);
      check_rsp($sformatf("vec%0d_rsp", i), {vecs[i].id, vecs[i].tag, vecs[i].exp_sum});
    end
    clear_reqs();
    @(negedge clk);

    // Contention: alternating grants after reset
    do_reset();
    bus.req_valid_0 = 1'b1; bus.req_a_0 = 59'd10; bus.req_b_0 = 26'd5; bus.req_tag_0 = 4'd3;
    bus.req_valid_1 = 1'b1; bus.req_a_1 = A_MAX;  bus.req_b_1 = 26'd2; bus.req_tag_1 = 4'd9;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) exp_q.push_back({1'b0, 4'd3, 60'd15});
      else            exp_q.push_back({1'b1, 4'd9, 60'h800_0000_0000_0001});
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      check_ready($sformatf("contend_ready%0d", k), (k % 2) == 0, (k % 2) == 1);
      @(negedge clk);
      check_rsp($sformatf("contend_rsp%0d", k), exp_q.pop_front());
    end

    // Backpressure: response held, readys low, grant order frozen
    bus.rsp_ready = 1'b0;
    #1;
    check_ready("bp_ready_initial", 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_rsp($sformatf("bp_hold%0d", k), {1'b1, 4'd9, 60'h800_0000_0000_0001});
      check_ready($sformatf("bp_ready%0d", k), 1'b0, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_ready("bp_resume_ready0", 1'b1, 1'b0);
    @(negedge clk);
    check_rsp("bp_resume_rsp0", {1'b0, 4'd3, 60'd15});
    check_ready("bp_resume_ready1", 1'b0, 1'b1);
    @(negedge clk);
    check_rsp("bp_resume_rsp1", {1'b1, 4'd9, 60'h800_0000_0000_0001});
    clear_reqs();
    @(negedge clk);

    // Burst: req1 locked for MAX_BURST beats, then req0
    do_reset();
    prime_req0();
    bus.req_valid_1 = 1'b1; bus.req_lock_1 = 1'b1;
    bus.req_a_1 = 59'd100; bus.req_b_1 = 26'd1; bus.req_tag_1 = 4'd12;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_ready($sformatf("burst_ready1_%0d", k), 1'b0, 1'b1);
      if (k > 0) check("burst_state_locked", {63'b0, dbg_state == ARB_LOCKED}, 64'd1);
      @(negedge clk);
      check_rsp($sformatf("burst_rsp%0d", k), {1'b1, 4'd12, 60'd101});
    end
    #1;
    check_ready("burst_end_ready0", 1'b1, 1'b0);
    check("burst_end_state", {63'b0, dbg_state == ARB_IDLE}, 64'd1);
    @(negedge clk);
    check_rsp("burst_end_rsp", {1'b0, 4'd3, 60'd15});
    clear_reqs();
    @(negedge clk);

    // Early release: lock=0 on req1's 2nd beat
    do_reset();
    prime_req0();
    bus.req_valid_1 = 1'b1; bus.req_lock_1 = 1'b1;
    bus.req_a_1 = 59'd7; bus.req_b_1 = 26'd8; bus.req_tag_1 = 4'd1;
    #1;
    check_ready("rel_ready_beat1", 1'b0, 1'b1);
    @(negedge clk);
    bus.req_lock_1 = 1'b0;
    #1;
    check_ready("rel_ready_beat2", 1'b0, 1'b1);
    @(negedge clk);
    check_rsp("rel_rsp_beat2", {1'b1, 4'd1, 60'd15});
    #1;
    check_ready("rel_ready_after", 1'b1, 1'b0);
    clear_reqs();
    @(negedge clk);

    // Reset mid-burst with a pending response
    do_reset();
    prime_req0();
    bus.req_valid_1 = 1'b1; bus.req_lock_1 = 1'b1;
    bus.req_a_1 = 59'd7; bus.req_b_1 = 26'd8; bus.req_tag_1 = 4'd1;
    @(negedge clk);
    check("rst_pre_locked", {63'b0, dbg_state == ARB_LOCKED}, 64'd1);
    check("rst_pre_valid", {63'b0, bus.rsp_valid}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check("rst_async_state", {63'b0, dbg_state == ARB_IDLE}, 64'd1);
    check("rst_async_last_grant", {63'b0, dbg_last_grant}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_lock_1 = 1'b0;
    #1;
    check_ready("rst_first_tie", 1'b1, 1'b0);
    @(negedge clk);
    check_rsp("rst_first_rsp", {1'b0, 4'd3, 60'd15});
    clear_reqs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wide_adder_arbiter.md
# wide_adder_arbiter

- Round-robin arbiter and sequencer that shares one 59-bit + 26-bit adder between two requesters.
- Sits in the multiply/accumulate datapath, where two mantissa pipelines both need the wide accumulate add.
- Each requester presents a 59-bit operand A, a 26-bit operand B and a tag over a valid/ready handshake.
- Results return on a single registered response channel with requester ID, tag and the 60-bit sum; an optional burst lock lets one requester stream back-to-back adds.

## Interface
- TAG_W, 4: width of the opaque request tag returned with the result.
- MAX_BURST, 8: maximum accepted beats per locked burst; range 1..255.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_0 / req_valid_1  in  1  request valid, per requester.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle when valid&&ready.
- req_a_0 / req_a_1  in  59  operand A.
- req_b_0 / req_b_1  in  26  operand B, zero-extended to 59 bits.
- req_tag_0 / req_tag_1  in  TAG_W  tag, echoed on the response.
- req_lock_0 / req_lock_1  in  1  request burst lock; sampled on accepted beats only.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index of the response.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_sum  out  60  A + {33'b0,B}, carry in bit 59.

## Operation
- out_free = !rsp_valid || rsp_ready.
- Grant logic is combinational from the req_valid signals, the FSM state and last_grant. At most one of req_ready_0 and req_ready_1 is high: req_ready_i = grant_i && out_free.
- FSM ARB_IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - On an accepted beat: last_grant <= i. If req_lock_i=1 and MAX_BURST>1, go to ARB_LOCKED with owner=i and burst_cnt=1.
- FSM ARB_LOCKED:
  - Only the owner can be granted; the other requester sees ready=0.
  - On an owner-accepted beat, burst_cnt increments.
  - Return to ARB_IDLE when any of the following holds:
    - the accepted beat has lock=0;
    - burst_cnt reaches MAX_BURST on an accepted beat;
    - the owner has req_valid=0 in a cycle where out_free=1 (idle release).
  - last_grant stays at owner, so the other requester wins the next tie.
- Arithmetic:
  - Unsigned: rsp_sum = A + zero-extended B, 60 bits, with no truncation.
  - Maximum value is (2^59−1)+(2^26−1); its carry lands in bit 59.
- Response register loads {id, tag, sum} on every accepted beat. It holds stable while rsp_valid && !rsp_ready.

## Timing
- Latency: a beat accepted at edge N gives rsp_valid=1 with its data after edge N, for one cycle or until rsp_ready.
- Throughput: 1 add/cycle when rsp_ready is held high; a drain and a new accept can occur in the same cycle.
- Backpressure: when rsp_valid && !rsp_ready, both ready outputs are 0, and lock and round-robin state freeze.
- Requesters must hold A, B, tag and lock stable while valid && !ready; valid must not drop before acceptance.
- Reset (async assert, sync deassert on clk):
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_sum=0.
  - State ARB_IDLE, last_grant=1 (requester 0 wins the first tie), burst_cnt=0.
- Reset mid-burst or mid-stall drops in-flight state. A pending response is discarded.

## Structure
- Package adder_arb_pkg holds:
  - localparams A_W=59, B_W=26, S_W=60;
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module: one instance of the existing customAdder59_33 (59-bit A, 26-bit B, 60-bit Sum) sits between the grant mux and the response register. The block adds no extra adder pipeline.
- The rest of the logic lives in a single always_ff with combinational grant logic.

## Test plan
- Single request:
  - Stimulus: req0 only, A=59'h1, B=26'h3FF_FFFF, tag=5, rsp_ready=1.
  - Response: accepted the same cycle; the next cycle gives rsp_valid=1, id=0, tag=5, sum=60'h400_0000.
- Carry out:
  - Stimulus: A=2^59−1, B=1.
  - Response: sum=60'h800_0000_0000_0000 (bit 59 set).
- Contention:
  - Stimulus: both requesters valid continuously for 6 beats after reset.
  - Response: grants in the order 0,1,0,1,0,1, one response per cycle with matching id and tag.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles while both requesters are valid.
  - Response: rsp_* held stable, both readys 0, no new response loaded; grant order resumes correctly afterwards.
- Burst:
  - Stimulus: MAX_BURST=3, req1 holds lock=1 with both requesters valid.
  - Response: req1 granted exactly 3 consecutive beats, then req0 granted. In a separate run, lock=0 on req1's 2nd beat releases after 2 beats.
- Reset:
  - Stimulus: assert rst_n mid-burst with rsp_valid=1.
  - Response: rsp_valid drops immediately (asynchronously); after release, FSM is in ARB_IDLE and req0 wins the first tie.
